data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//   Sequences and shares the single-port synchronous DataMemory between the CPU load/store
//   path (address-decoder memory side) and a loader/debug requester. Replaces the inline
//   bus_busy/bus_counter stall logic: issues one memory strobe per access, holds cpu_stall
//   (which freezes pc_current) for WAIT_CYCLES cycles, and round-robins on contention.
// PARAMETERS
//   WAIT_CYCLES  1   stall cycles per access, legal range 1..15 (1 = original timing)
// PORTS
//   clk              in   1   system clock, all state on rising edge
//   rst_n            in   1   synchronous reset, active low
//   cpu_read_en      in   1   CPU load request (mem_read_en from address decoder)
//   cpu_write_en     in   1   CPU store request
//   cpu_address      in   32  CPU byte address
//   cpu_write_value  in   32  CPU store data
//   cpu_data_size    in   3   CPU access size code, passed through unchanged
//   cpu_read_value   out  32  load data to datapath (mem_read_value pass-through)
//   cpu_stall        out  1   high = datapath must hold PC and request signals
//   ldr_req          in   1   loader request, held high until ldr_done
//   ldr_write_en     in   1   1 = write, 0 = read; stable while ldr_req high
//   ldr_address      in   32  loader byte address
//   ldr_write_value  in   32  loader write data
//   ldr_data_size    in   3   loader access size code
//   ldr_done         out  1   one-cycle completion pulse
//   ldr_read_value   out  32  loader read data, registered, valid from ldr_done onward
//   mem_address      out  32  to DataMemory mem_access_addr
//   mem_write_value  out  32  to DataMemory mem_in
//   mem_data_size    out  3   to DataMemory mem_data_size
//   mem_read_en      out  1   read strobe, exactly one cycle per read access
//   mem_write_en     out  1   write strobe, exactly one cycle per write access
//   mem_read_value   in   32  from DataMemory mem_out, valid cycle after strobe, held
// BEHAVIOUR
//   States: IDLE, CPU_ACC, CPU_DONE, LDR_ACC, LDR_DONE; 4-bit wait counter; last_owner bit.
//   cpu_req = cpu_read_en | cpu_write_en. Requesters hold all request signals stable until
//   completion (CPU via cpu_stall, loader until ldr_done).
//   IDLE: grant decided combinationally this cycle. Only cpu_req -> CPU; only ldr_req ->
//     loader; both -> owner != last_owner. Granted cycle = access cycle 1: strobe issued
//     (read_en or write_en per request; if both CPU enables high, write wins), mem_* muxed
//     from granted requester, last_owner updated. Next state: W=1 -> *_DONE, else *_ACC
//     with counter = W-1.
//   cpu_stall = 1 in IDLE when cpu_req (CPU granted or not), in CPU_ACC, and in LDR_ACC/
//     LDR_DONE when cpu_req; 0 in CPU_DONE and IDLE without cpu_req.
//   *_ACC: strobes 0, mem_address/write_value/data_size still muxed from owner; counter
//     decrements; at counter==1 go to *_DONE.
//   CPU_DONE: stall 0, strobes 0, cpu_read_value = mem_read_value; CPU's still-asserted
//     enables ignored (PC advances this edge). Next: IDLE.
//   LDR_DONE: ldr_done=1, ldr_read_value <= mem_read_value on this edge (reads only; held
//     for writes); ldr_req still high is ignored. Next: IDLE; ldr_req high in a later IDLE
//     cycle is a new access.
//   CPU access latency: exactly W stall cycles then 1 completion cycle. Loader access:
//     ldr_done W cycles after grant cycle. Loser of contention waits one full access + 1.
//   mem_* when no owner (IDLE, no request, or *_DONE): address/data/size 0, strobes 0.
//   Reset (rst_n low at edge, any state incl. mid-access): state IDLE, counter 0,
//     last_owner = loader (CPU wins first tie), ldr_read_value 0. While rst_n low:
//     cpu_stall, ldr_done, mem_read_en, mem_write_en forced 0; aborted access not resumed.
// TESTING
//   W=1, CPU load 0x40: stall high 1 cycle, mem_read_en 1 cycle, next cycle stall 0 and
//     cpu_read_value = stored word; PC advances exactly once.
//   W=3, CPU store 0xDEADBEEF to 0x80: stall high 3 cycles, mem_write_en high only in first;
//     later load of 0x80 returns 0xDEADBEEF.
//   Same-cycle CPU load + ldr_req write after reset: CPU granted first (stall W cycles), loader
//     granted in the IDLE after CPU_DONE, ldr_done W cycles later; next tie goes to CPU only
//     if loader was last owner.
//   CPU request arriving during LDR_ACC: cpu_stall high throughout loader access and own
//     access; no strobe issued for CPU until loader's LDR_DONE passed.
//   Loader read of 0x100 holding 0x12345678: ldr_done single pulse, ldr_read_value =
//     0x12345678 and held after ldr_req drops.
//   rst_n low during CPU_ACC (W=4): next cycle IDLE, all strobes/stall 0; exactly one
//     strobe observed for the aborted access.

Source files
------------

// File: rtl/data_bus_arbiter_if.sv
// Bundle of CPU, loader and DataMemory signals around the data bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface data_bus_arbiter_if;
    logic        cpu_read_en;
    logic        cpu_write_en;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_value;
    logic [2:0]  cpu_data_size;
    logic [31:0] cpu_read_value;
    logic        cpu_stall;

    logic        ldr_req;
    logic        ldr_write_en;
    logic [31:0] ldr_address;
    logic [31:0] ldr_write_value;
    logic [2:0]  ldr_data_size;
    logic        ldr_done;
    logic [31:0] ldr_read_value;

    logic [31:0] mem_address;
    logic [31:0] mem_write_value;
    logic [2:0]  mem_data_size;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_read_value;

    modport slave (
        input  cpu_read_en, cpu_write_en, cpu_address, cpu_write_value, cpu_data_size,
        output cpu_read_value, cpu_stall,
        input  ldr_req, ldr_write_en, ldr_address, ldr_write_value, ldr_data_size,
        output ldr_done, ldr_read_value,
        output mem_address, mem_write_value, mem_data_size, mem_read_en, mem_write_en,
        input  mem_read_value
    );

    modport master (
        output cpu_read_en, cpu_write_en, cpu_address, cpu_write_value, cpu_data_size,
        input  cpu_read_value, cpu_stall,
        output ldr_req, ldr_write_en, ldr_address, ldr_write_value, ldr_data_size,
        input  ldr_done, ldr_read_value,
        input  mem_address, mem_write_value, mem_data_size, mem_read_en, mem_write_en,
        output mem_read_value
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Shares the single-port DataMemory between the CPU load/store path and a loader,
// issuing one strobe per access, stalling the CPU WAIT_CYCLES cycles, round-robin on ties.
module data_bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    data_bus_arbiter_if.slave bus
);

    localparam int W_EFF = (WAIT_CYCLES < 1) ? 1 : ((WAIT_CYCLES > 15) ? 15 : WAIT_CYCLES);
    localparam logic [3:0] W_M1 = 4'(W_EFF - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CPU_ACC  = 3'd1;
    localparam logic [2:0] CPU_DONE = 3'd2;
    localparam logic [2:0] LDR_ACC  = 3'd3;
    localparam logic [2:0] LDR_DONE = 3'd4;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_owner_q, last_owner_d;
    logic [31:0] ldr_read_value_q, ldr_read_value_d;

    logic cpu_req;
    logic grant_cpu;
    logic grant_ldr;
    logic sel_cpu;
    logic sel_ldr;
    logic rd_strobe;
    logic wr_strobe;
    logic stall;
    logic done;

    assign cpu_req   = bus.cpu_read_en | bus.cpu_write_en;
    // On a tie the requester that did not own the bus last goes first.
    assign grant_cpu = cpu_req & (~bus.ldr_req | (last_owner_q == OWN_LDR));
    assign grant_ldr = bus.ldr_req & (~cpu_req | (last_owner_q == OWN_CPU));

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        last_owner_d     = last_owner_q;
        ldr_read_value_d = ldr_read_value_q;
        sel_cpu          = 1'b0;
        sel_ldr          = 1'b0;
        rd_strobe        = 1'b0;
        wr_strobe        = 1'b0;
        stall            = 1'b0;
        done             = 1'b0;

        case (state_q)
            IDLE: begin
                stall = cpu_req;
                if (grant_cpu) begin
                    sel_cpu      = 1'b1;
                    wr_strobe    = bus.cpu_write_en;
                    rd_strobe    = bus.cpu_read_en & ~bus.cpu_write_en;
                    last_owner_d = OWN_CPU;
                    cnt_d        = W_M1;
                    state_d      = (W_M1 == 4'd0) ? CPU_DONE : CPU_ACC;
                end else if (grant_ldr) begin
                    sel_ldr      = 1'b1;
                    wr_strobe    = bus.ldr_write_en;
                    rd_strobe    = ~bus.ldr_write_en;
                    last_owner_d = OWN_LDR;
                    cnt_d        = W_M1;
                    state_d      = (W_M1 == 4'd0) ? LDR_DONE : LDR_ACC;
                end
            end
            CPU_ACC: begin
                stall   = 1'b1;
                sel_cpu = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = CPU_DONE;
                end
            end
            CPU_DONE: begin
                // Enables still high here belong to the finished access; PC moves on.
                state_d = IDLE;
            end
            LDR_ACC: begin
                stall   = cpu_req;
                sel_ldr = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = LDR_DONE;
                end
            end
            LDR_DONE: begin
                stall = cpu_req;
                done  = 1'b1;
                if (!bus.ldr_write_en) begin
                    ldr_read_value_d = bus.mem_read_value;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.mem_address     = 32'd0;
        bus.mem_write_value = 32'd0;
        bus.mem_data_size   = 3'd0;
        if (sel_cpu) begin
            bus.mem_address     = bus.cpu_address;
            bus.mem_write_value = bus.cpu_write_value;
            bus.mem_data_size   = bus.cpu_data_size;
        end else if (sel_ldr) begin
            bus.mem_address     = bus.ldr_address;
            bus.mem_write_value = bus.ldr_write_value;
            bus.mem_data_size   = bus.ldr_data_size;
        end
    end

    // Handshake outputs are squelched while reset is held so nothing leaks mid-abort.
    assign bus.mem_read_en    = rd_strobe & rst_n;
    assign bus.mem_write_en   = wr_strobe & rst_n;
    assign bus.cpu_stall      = stall & rst_n;
    assign bus.ldr_done       = done & rst_n;
    assign bus.cpu_read_value = bus.mem_read_value;
    assign bus.ldr_read_value = ldr_read_value_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            last_owner_q     <= OWN_LDR;
            ldr_read_value_q <= 32'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            last_owner_q     <= last_owner_d;
            ldr_read_value_q <= ldr_read_value_d;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: one instance with WAIT_CYCLES=3, one with
// WAIT_CYCLES=1, each backed by a small synchronous word memory.
module tb_data_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   ncmp  = 0;
    int   nfail = 0;

    int rd3 = 0, wr3 = 0, pc3 = 0, pc1 = 0;
    int rdb, wrb, pcb;

    logic [31:0] mem3 [0:255];
    logic [31:0] mem1 [0:255];

    data_bus_arbiter_if bus3 ();
    data_bus_arbiter_if bus1 ();

    data_bus_arbiter #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    data_bus_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    // Memories reload their contents whenever reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem3[i] <= 32'd0;
            mem3[16] <= 32'hA5A5_0040;
            mem3[64] <= 32'h1234_5678;
            bus3.mem_read_value <= 32'd0;
        end else begin
            if (bus3.mem_write_en) mem3[bus3.mem_address[9:2]] <= bus3.mem_write_value;
            if (bus3.mem_read_en) bus3.mem_read_value <= mem3[bus3.mem_address[9:2]];
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem1[i] <= 32'd0;
            mem1[16] <= 32'hCAFE_0040;
            bus1.mem_read_value <= 32'd0;
        end else begin
            if (bus1.mem_write_en) mem1[bus1.mem_address[9:2]] <= bus1.mem_write_value;
            if (bus1.mem_read_en) bus1.mem_read_value <= mem1[bus1.mem_address[9:2]];
        end
    end

    // Strobe and PC-advance counters (PC advances when a request is not stalled).
    always @(posedge clk) begin
        if (bus3.mem_read_en) rd3 <= rd3 + 1;
        if (bus3.mem_write_en) wr3 <= wr3 + 1;
        if (rst_n && (bus3.cpu_read_en || bus3.cpu_write_en) && !bus3.cpu_stall) pc3 <= pc3 + 1;
        if (rst_n && (bus1.cpu_read_en || bus1.cpu_write_en) && !bus1.cpu_stall) pc1 <= pc1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        bus3.cpu_read_en = 0; bus3.cpu_write_en = 0; bus3.cpu_address = 0;
        bus3.cpu_write_value = 0; bus3.cpu_data_size = 0;
        bus3.ldr_req = 0; bus3.ldr_write_en = 0; bus3.ldr_address = 0;
        bus3.ldr_write_value = 0; bus3.ldr_data_size = 0;
        bus1.cpu_read_en = 0; bus1.cpu_write_en = 0; bus1.cpu_address = 0;
        bus1.cpu_write_value = 0; bus1.cpu_data_size = 0;
        bus1.ldr_req = 0; bus1.ldr_write_en = 0; bus1.ldr_address = 0;
        bus1.ldr_write_value = 0; bus1.ldr_data_size = 0;
        repeat (2) cyc();

        // Reset: requests present but every handshake output held low
        bus3.cpu_read_en = 1; bus3.ldr_req = 1;
        #1;
        chk("rst_stall", bus3.cpu_stall, 0);
        chk("rst_done", bus3.ldr_done, 0);
        chk("rst_rd", bus3.mem_read_en, 0);
        chk("rst_wr", bus3.mem_write_en, 0);
        chk("rst_ldr_val", bus3.ldr_read_value, 0);
        bus3.cpu_read_en = 0; bus3.ldr_req = 0;
        rst_n = 1'b1;
        cyc();
        chk("idle_stall", bus3.cpu_stall, 0);
        chk("idle_addr", bus3.mem_address, 0);

        // W=3 CPU store 0xDEADBEEF to 0x80
        bus3.cpu_write_en = 1; bus3.cpu_address = 32'h80;
        bus3.cpu_write_value = 32'hDEAD_BEEF; bus3.cpu_data_size = 3'd2;
        #1;
        chk("st_stall1", bus3.cpu_stall, 1);
        chk("st_wr1", bus3.mem_write_en, 1);
        chk("st_rd1", bus3.mem_read_en, 0);
        chk("st_addr1", bus3.mem_address, 32'h80);
        chk("st_wval1", bus3.mem_write_value, 32'hDEAD_BEEF);
        chk("st_size1", bus3.mem_data_size, 2);
        cyc();
        chk("st_stall2", bus3.cpu_stall, 1);
        chk("st_wr2", bus3.mem_write_en, 0);
        chk("st_addr2", bus3.mem_address, 32'h80);
        cyc();
        chk("st_stall3", bus3.cpu_stall, 1);
        chk("st_wr3", bus3.mem_write_en, 0);
        cyc();
        chk("st_done_stall", bus3.cpu_stall, 0);
        chk("st_done_wr", bus3.mem_write_en, 0);
        chk("st_done_addr", bus3.mem_address, 0);
        chk("st_done_size", bus3.mem_data_size, 0);
        cyc();
        bus3.cpu_write_en = 0;
        #1;
        chk("st_wr_count", wr3, 1);

        // W=3 CPU load of 0x80 returns the stored word; PC advances once
        pcb = pc3; rdb = rd3;
        bus3.cpu_read_en = 1; bus3.cpu_address = 32'h80;
        #1;
        chk("ld_stall1", bus3.cpu_stall, 1);
        chk("ld_rd1", bus3.mem_read_en, 1);
        cyc();
        chk("ld_rd2", bus3.mem_read_en, 0);
        cyc();
        chk("ld_stall3", bus3.cpu_stall, 1);
        cyc();
        chk("ld_done_stall", bus3.cpu_stall, 0);
        chk("ld_value", bus3.cpu_read_value, 32'hDEAD_BEEF);
        cyc();
        bus3.cpu_read_en = 0;
        #1;
        chk("ld_pc_adv", pc3 - pcb, 1);
        chk("ld_rd_count", rd3 - rdb, 1);

        // Fresh reset, then a tie: CPU load 0x40 vs loader write 0x0BADF00D to 0xC0
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        bus3.cpu_read_en = 1; bus3.cpu_address = 32'h40;
        bus3.ldr_req = 1; bus3.ldr_write_en = 1; bus3.ldr_address = 32'hC0;
        bus3.ldr_write_value = 32'h0BAD_F00D; bus3.ldr_data_size = 3'd2;
        #1;
        chk("tie1_addr", bus3.mem_address, 32'h40);
        chk("tie1_rd", bus3.mem_read_en, 1);
        chk("tie1_wr", bus3.mem_write_en, 0);
        chk("tie1_stall", bus3.cpu_stall, 1);
        cyc();
        cyc();
        chk("tie1_acc_stall", bus3.cpu_stall, 1);
        chk("tie1_acc_done", bus3.ldr_done, 0);
        cyc();
        chk("tie1_cdone_stall", bus3.cpu_stall, 0);
        chk("tie1_cdone_val", bus3.cpu_read_value, 32'hA5A5_0040);
        chk("tie1_cdone_ldone", bus3.ldr_done, 0);
        cyc();
        bus3.cpu_read_en = 0;
        #1;
        chk("ldrw_wr", bus3.mem_write_en, 1);
        chk("ldrw_addr", bus3.mem_address, 32'hC0);
        chk("ldrw_wval", bus3.mem_write_value, 32'h0BAD_F00D);
        chk("ldrw_stall", bus3.cpu_stall, 0);
        cyc();
        cyc();
        chk("ldrw_acc_done", bus3.ldr_done, 0);
        cyc();
        chk("ldrw_done", bus3.ldr_done, 1);
        chk("ldrw_done_addr", bus3.mem_address, 0);
        cyc();
        bus3.ldr_req = 0;
        #1;
        chk("ldrw_done_pulse", bus3.ldr_done, 0);

        // Second tie (loader owned last): CPU load 0xC0 wins over loader read 0x100
        bus3.cpu_read_en = 1; bus3.cpu_address = 32'hC0;
        bus3.ldr_req = 1; bus3.ldr_write_en = 0; bus3.ldr_address = 32'h100;
        #1;
        chk("tie2_addr", bus3.mem_address, 32'hC0);
        cyc();
        cyc();
        cyc();
        chk("tie2_cdone_val", bus3.cpu_read_value, 32'h0BAD_F00D);
        cyc();
        // New CPU request against the waiting loader: CPU owned last, loader wins
        bus3.cpu_address = 32'h40;
        #1;
        chk("tie3_addr", bus3.mem_address, 32'h100);
        chk("tie3_rd", bus3.mem_read_en, 1);
        chk("tie3_stall", bus3.cpu_stall, 1);
        cyc();
        chk("lacc_stall", bus3.cpu_stall, 1);
        chk("lacc_rd", bus3.mem_read_en, 0);
        chk("lacc_addr", bus3.mem_address, 32'h100);
        cyc();
        chk("lacc2_stall", bus3.cpu_stall, 1);
        cyc();
        chk("ldone_pulse", bus3.ldr_done, 1);
        chk("ldone_stall", bus3.cpu_stall, 1);
        chk("ldone_rd", bus3.mem_read_en, 0);
        cyc();
        chk("ldr_val", bus3.ldr_read_value, 32'h1234_5678);
        bus3.ldr_req = 0;
        #1;
        chk("cpu_after_ldr_addr", bus3.mem_address, 32'h40);
        chk("cpu_after_ldr_rd", bus3.mem_read_en, 1);
        chk("cpu_after_ldr_stall", bus3.cpu_stall, 1);
        chk("cpu_after_ldr_done", bus3.ldr_done, 0);
        cyc();
        cyc();
        chk("ldr_val_held", bus3.ldr_read_value, 32'h1234_5678);
        cyc();
        chk("cpu_after_ldr_val", bus3.cpu_read_value, 32'hA5A5_0040);
        chk("cpu_after_ldr_dstall", bus3.cpu_stall, 0);
        cyc();
        bus3.cpu_read_en = 0;

        // Reset during CPU_ACC aborts the store after its single strobe
        wrb = wr3;
        bus3.cpu_write_en = 1; bus3.cpu_address = 32'h200; bus3.cpu_write_value = 32'h1111_2222;
        #1;
        chk("abort_wr1", bus3.mem_write_en, 1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("abort_rst_stall", bus3.cpu_stall, 0);
        chk("abort_rst_wr", bus3.mem_write_en, 0);
        chk("abort_rst_rd", bus3.mem_read_en, 0);
        cyc();
        rst_n = 1'b1;
        bus3.cpu_write_en = 0;
        #1;
        chk("abort_idle_stall", bus3.cpu_stall, 0);
        chk("abort_idle_wr", bus3.mem_write_en, 0);
        chk("abort_ldr_val_rst", bus3.ldr_read_value, 0);
        cyc();
        chk("abort_wr_count", wr3 - wrb, 1);
        chk("abort_end_stall", bus3.cpu_stall, 0);

        // W=1 CPU load of 0x40: one stall cycle, then data
        bus1.cpu_read_en = 1; bus1.cpu_address = 32'h40;
        #1;
        chk("w1_stall", bus1.cpu_stall, 1);
        chk("w1_rd", bus1.mem_read_en, 1);
        cyc();
        chk("w1_done_stall", bus1.cpu_stall, 0);
        chk("w1_done_rd", bus1.mem_read_en, 0);
        chk("w1_val", bus1.cpu_read_value, 32'hCAFE_0040);
        cyc();
        bus1.cpu_read_en = 0;
        #1;
        chk("w1_pc_adv", pc1, 1);

        // W=1 loader read of 0x40: ldr_done one cycle after grant
        bus1.ldr_req = 1; bus1.ldr_write_en = 0; bus1.ldr_address = 32'h40;
        #1;
        chk("w1_ldr_rd", bus1.mem_read_en, 1);
        chk("w1_ldr_stall", bus1.cpu_stall, 0);
        cyc();
        chk("w1_ldr_done", bus1.ldr_done, 1);
        cyc();
        bus1.ldr_req = 0;
        #1;
        chk("w1_ldr_val", bus1.ldr_read_value, 32'hCAFE_0040);
        chk("w1_ldr_done_pulse", bus1.ldr_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
